bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_to_bin_seq_if.sv | 17 +
 rtl/bcd_digit_sub3.sv | 9 +
 rtl/bcd_to_bin_seq.sv | 115 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the packed-BCD to binary converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_valid(bcd_digit_t digit);
        return (digit <= bcd_digit_t'(9));
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/done handshake bundle between a requester and bcd_to_bin_seq.
interface bcd_to_bin_seq_if
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
);
    logic                          start;
    logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in;
    logic                          busy;
    logic                          done;
    logic [BIN_W-1:0]              bin_out;
    logic                          err;

    modport master (output start, bcd_in, input busy, done, bin_out, err);
    modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble digit correction: digits of 8 or more lose 3.
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);
    assign dout = (din >= bcd_digit_t'(8)) ? bcd_digit_t'(din - bcd_digit_t'(3)) : din;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter, one result bit per clock.
// Optional input digit validation enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_W      = 14
)(
    input  logic             clk,
    input  logic             rst,
    bcd_to_bin_seq_if.slave  bus
);
    localparam int unsigned BCD_W  = DIGIT_W * NUM_DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_DEC = (64'd10 ** NUM_DIGITS) - 64'd1;

    if ((64'd1 << BIN_W) <= MAX_DEC) begin : g_width_check
        $error("bcd_to_bin_seq: BIN_W too narrow for NUM_DIGITS");
    end

    state_t             state, state_next;
    logic [WORK_W-1:0]  work, work_next, shifted;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [BIN_W-1:0]   bin_q, bin_next;
    logic               err_q, err_next;
    logic               busy_q, done_q;
    logic [BCD_W-1:0]   adj_bcd;
    logic               in_bad;

    assign shifted = work >> 1;

    // Correct every digit of the already-shifted bcd part.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_sub3
        bcd_digit_sub3 u_sub3 (
            .din  (shifted[BIN_W + i*DIGIT_W +: DIGIT_W]),
            .dout (adj_bcd[i*DIGIT_W +: DIGIT_W])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!digit_valid(bus.bcd_in[i*DIGIT_W +: DIGIT_W])) in_bad = 1'b1;
        end
    end
`else
    assign in_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        work_next  = work;
        cnt_next   = cnt;
        bin_next   = bin_q;
        err_next   = err_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (in_bad) begin
                        bin_next   = '0;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        work_next  = {bus.bcd_in, BIN_W'(0)};
                        cnt_next   = '0;
                        state_next = CONV;
                    end
                end
            end
            CONV: begin
                work_next = {adj_bcd, shifted[BIN_W-1:0]};
                cnt_next  = CNT_W'(cnt + CNT_W'(1));
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    bin_next   = shifted[BIN_W-1:0];
                    err_next   = 1'b0;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            work   <= work_next;
            cnt    <= cnt_next;
            bin_q  <= bin_next;
            err_q  <= err_next;
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == DONE);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bin_out = bin_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq (default 4 digits, 14-bit result).
module tb_bcd_to_bin_seq;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BIN_W      = 14;
    localparam int unsigned LAT        = BIN_W;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               start_cyc;
        bit               short_path;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    bcd_to_bin_seq_if #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin_seq #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    function automatic int bcd_val(input logic [15:0] b);
        int v = 0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
        return v;
    endfunction

    // Drive one start pulse; optionally register the expected completion.
    task automatic start_conv(input logic [15:0] bcd, input bit push,
                              input logic exp_err, input bit short_path);
        exp_t e;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(posedge clk);
        #1;
        if (push) begin
            e.bin        = exp_err ? '0 : BIN_W'(bcd_val(bcd));
            e.err        = exp_err;
            e.start_cyc  = cyc;
            e.short_path = short_path;
            sb.push_back(e);
        end
        bus.start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Compare every completion against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bin_out", 32'(bus.bin_out), 32'(e.bin));
                check("err", 32'(bus.err), 32'(e.err));
                check("busy_at_done", 32'(bus.busy), 32'd1);
                if (e.short_path) check("short_latency", 32'((cyc - e.start_cyc) <= 2), 32'd1);
                else              check("latency", 32'(cyc - e.start_cyc), 32'(LAT));
            end
        end
    end

    initial begin
        logic [15:0] r;
        int n;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bin", 32'(bus.bin_out), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        rst = 1'b0;

        start_conv(16'h0000, 1'b1, 1'b0, 1'b0);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        wait_drain();
        start_conv(16'h1234, 1'b1, 1'b0, 1'b0);
        wait_drain();
        start_conv(16'h9999, 1'b1, 1'b0, 1'b0);
        wait_drain();
        start_conv(16'h0001, 1'b1, 1'b0, 1'b0);
        wait_drain();

`ifdef BCD2BIN_CHECK_EN
        start_conv(16'h12A4, 1'b1, 1'b1, 1'b1);
        wait_drain();
        start_conv(16'h0042, 1'b1, 1'b0, 1'b0);
        wait_drain();
`endif

        for (int k = 0; k < 6; k++) begin
            for (int d = 0; d < 4; d++) r[d*4 +: 4] = 4'($urandom_range(0, 9));
            start_conv(r, 1'b1, 1'b0, 1'b0);
            wait_drain();
        end

        // Start while busy is dropped.
        start_conv(16'h5678, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        start_conv(16'h0001, 1'b0, 1'b0, 1'b0);
        wait_drain();
        repeat (3) @(posedge clk);

        // Start held through DONE is taken on the first IDLE edge.
        start_conv(16'h0012, 1'b1, 1'b0, 1'b0);
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0034;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 100);
        check("idle_timeout", 32'(bus.busy), 32'd0);
        check("first_done_seen", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.bin = BIN_W'(34); e.err = 1'b0; e.start_cyc = cyc; e.short_path = 1'b0;
            sb.push_back(e);
        end
        check("busy_restart", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_drain();

        // Asynchronous reset mid-conversion.
        start_conv(16'h4321, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_bin", 32'(bus.bin_out), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        start_conv(16'h0777, 1'b1, 1'b0, 1'b0);
        wait_drain();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
